// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, R-type funct constants and issue FSM state encoding
package alu_pkg;
  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [6:0] FUNCT7_BASE    = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT     = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV  = 7'b0000001;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: maps (funct7, funct3) to ALU control code, MUL flag and illegal flag
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [3:0] alu_ctrl,
  output logic       is_mul,
  output logic       illegal
);
  logic base, alt;
  always_comb begin
    base = funct7 == FUNCT7_BASE;
    alt = funct7 == FUNCT7_ALT;
    is_mul = funct7 == FUNCT7_MULDIV && funct3 == FUNCT3_ADD_SUB;
    alu_ctrl = base && funct3 == FUNCT3_ADD_SUB ? ALU_ADD :
               alt  && funct3 == FUNCT3_ADD_SUB ? ALU_SUB :
               base && funct3 == FUNCT3_AND     ? ALU_AND :
               base && funct3 == FUNCT3_OR      ? ALU_OR  :
               is_mul                           ? ALU_ADD : ALU_NOP;
    illegal = alu_ctrl == ALU_NOP;
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: req/rsp front end for a combinational ALU; decodes R-type ops and runs MUL as shift-and-add ALU passes
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [6:0]      req_funct7,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result
);
  state_t state, state_n;
  logic [3:0] dec_ctrl, op_ctrl;
  logic dec_mul, dec_illegal, accept;
  logic [XLEN-1:0] op_a, op_b, acc, mcand, mplier;
  logic [5:0] cnt;
  alu_op_decode u_dec (
    .funct7(req_funct7),
    .funct3(req_funct3),
    .alu_ctrl(dec_ctrl),
    .is_mul(dec_mul),
    .illegal(dec_illegal)
  );
  always_ff @(posedge clk) state <= reset ? S_IDLE : state_n;
  always_comb begin
    state_n = state;
    req_ready = 1'b0;
    alu_a = '0;
    alu_b = '0;
    alu_ctrl = ALU_NOP;
    case (state)
      S_IDLE: begin
        req_ready = !reset;
        if (req_valid)
          state_n = dec_illegal || (dec_mul && req_b == '0) ? S_DONE : dec_mul ? S_MUL : S_EXEC;
      end
      S_EXEC: begin
        alu_a = op_a;
        alu_b = op_b;
        alu_ctrl = op_ctrl;
        state_n = S_DONE;
      end
      S_MUL: begin
        alu_a = acc;
        alu_b = mcand;
        alu_ctrl = ALU_ADD;
        if ((mplier >> 1) == '0 || cnt == 6'd31) state_n = S_DONE;
      end
      default: if (rsp_ready) state_n = S_IDLE;
    endcase
  end
  assign accept = req_ready && req_valid;
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      op_ctrl <= ALU_NOP;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
    end else begin
      rsp_valid <= state_n == S_DONE;
      case (state)
        S_IDLE: if (accept) begin
          op_a <= req_a;
          op_b <= req_b;
          op_ctrl <= dec_ctrl;
          acc <= '0;
          mcand <= req_a;
          mplier <= req_b;
          cnt <= '0;
          if (state_n == S_DONE) begin
            rsp_data <= '0;
            rsp_err <= dec_illegal;
          end
        end
        S_EXEC: begin
          rsp_data <= alu_result;
          rsp_err <= 1'b0;
        end
        S_MUL: begin
          if (mplier[0]) acc <= alu_result;
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
          cnt <= cnt + 6'd1;
          if (state_n == S_DONE) begin
            rsp_data <= mplier[0] ? alu_result : acc;
            rsp_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and random checks of alu_issue_ctrl against a behavioural model with a bench-side ALU
module tb_alu_issue_ctrl;
  import alu_pkg::*;
  logic clk = 0, reset = 1, req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_err;
  logic [2:0] req_funct3 = 0;
  logic [6:0] req_funct7 = 0;
  logic [31:0] req_a = 0, req_b = 0, rsp_data, alu_a, alu_b, alu_result;
  logic [3:0] alu_ctrl;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_issue_ctrl #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_funct7(req_funct7), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result)
  );
  always_comb
    case (alu_ctrl)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      default: alu_result = 32'h0;
    endcase
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic err, output int lat, output logic [3:0] c1, output logic mul);
    r = 0; err = 0; lat = 2; c1 = 0; mul = 0;
    if (f7 == 7'h00 && f3 == 3'b000) begin r = a + b; c1 = 4'd1; end
    else if (f7 == 7'h20 && f3 == 3'b000) begin r = a - b; c1 = 4'd2; end
    else if (f7 == 7'h00 && f3 == 3'b111) begin r = a & b; c1 = 4'd3; end
    else if (f7 == 7'h00 && f3 == 3'b110) begin r = a | b; c1 = 4'd4; end
    else if (f7 == 7'h01 && f3 == 3'b000) begin
      mul = 1;
      r = a * b;
      lat = 1;
      for (int i = 0; i < 32; i++) if (b[i]) lat = i + 2;
      c1 = b != 0 ? 4'd1 : 4'd0;
    end else begin err = 1; lat = 1; end
  endfunction
  task automatic send(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!req_ready && w < 50) begin step(); w++; end
    chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid = 1; req_funct7 = f7; req_funct3 = f3; req_a = a; req_b = b;
    step();
    req_valid = 0; req_a = $urandom; req_b = $urandom;
  endtask
  task automatic txn(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] r;
    logic err, mul;
    logic [3:0] c1;
    int lat, n;
    model(f7, f3, a, b, r, err, lat, c1, mul);
    send(f7, f3, a, b);
    chk("ctrl_cycle1", {28'b0, alu_ctrl}, {28'b0, c1});
    chk("alu_a_cycle1", alu_a, c1 == 0 || mul ? 32'h0 : a);
    chk("alu_b_cycle1", alu_b, c1 == 0 ? 32'h0 : mul ? a : b);
    n = 1;
    while (!rsp_valid && n < 40) begin step(); n++; end
    chk("latency", n, lat);
    chk("rsp_data", rsp_data, r);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, err});
    chk("ctrl_done", {28'b0, alu_ctrl}, 32'h0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_data", rsp_data, r);
      chk("hold_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("post_valid", {31'b0, rsp_valid}, 32'd0);
    chk("post_ready", {31'b0, req_ready}, 32'd1);
  endtask
  initial begin
    logic [9:0] ops [6];
    logic [9:0] op;
    logic [31:0] a, b;
    ops = '{{7'h00, 3'b000}, {7'h20, 3'b000}, {7'h00, 3'b111}, {7'h00, 3'b110}, {7'h01, 3'b000}, {7'h00, 3'b001}};
    step(); step();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
    reset = 0;
    step();
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);
    txn(7'h00, 3'b000, 32'h5, 32'h3, 0);
    txn(7'h20, 3'b000, 32'h0, 32'h1, 0);
    txn(7'h00, 3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    txn(7'h00, 3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    txn(7'h01, 3'b000, 32'h7, 32'h6, 0);
    txn(7'h01, 3'b000, 32'h1234, 32'h0, 0);
    txn(7'h01, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    txn(7'h00, 3'b001, 32'hDEAD_BEEF, 32'h1, 0);
    txn(7'h00, 3'b000, 32'h1111_2222, 32'h3333_4444, 5);
    send(7'h01, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 9; i++) step();
    chk("mid_mul_ctrl", {28'b0, alu_ctrl}, 32'd1);
    reset = 1;
    step();
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort_rsp_data", rsp_data, 32'h0);
    chk("abort_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("abort_alu_a", alu_a, 32'h0);
    chk("abort_alu_b", alu_b, 32'h0);
    chk("abort_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
    chk("abort_req_ready", {31'b0, req_ready}, 32'd0);
    reset = 0;
    step();
    chk("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
    txn(7'h00, 3'b000, 32'hFFFF_FFFF, 32'h2, 0);
    for (int t = 0; t < 40; t++) begin
      op = ops[$urandom_range(0, 5)];
      if (t % 8 == 7) op = 10'($urandom);
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (t % 10 == 3) b = 0;
      txn(op[9:3], op[2:0], a, b, $urandom_range(0, 3));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential front end that drives the combinational ALU in the single-cycle datapath. It accepts decoded R-type requests (funct3/funct7 plus two operands) over a valid/ready handshake and encodes them into the ALU's 4-bit control code. It drives the ALU operand ports, captures the ALU result and returns it over a valid/ready response channel. It also sequences a 32-bit low-half multiply as repeated ALU ADD passes, so MUL needs no dedicated adder.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_funct3` in 3: RISC-V funct3.
- `req_funct7` in 7: RISC-V funct7.
- `req_a` in XLEN: operand A (rs1).
- `req_b` in XLEN: operand B (rs2).
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out XLEN: result.
- `rsp_err` out 1: unsupported funct encoding.
- `alu_a` out XLEN: ALU operand A.
- `alu_b` out XLEN: ALU operand B.
- `alu_ctrl` out 4: ALU control code.
- `alu_result` in XLEN: ALU result (combinational from alu_a/alu_b/alu_ctrl).

## Operation
- ALU codes: ADD=0001, SUB=0010, AND=0011, OR=0100, NOP=0000. With NOP the ALU returns 0.
- Decode (funct7, funct3):
  - (0000000, 000) → ADD
  - (0100000, 000) → SUB
  - (0000000, 111) → AND
  - (0000000, 110) → OR
  - (0000001, 000) → MUL
  - anything else → illegal.
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE:
  - `req_ready`=1.
  - On accept: latch operands and decode into `op_a`/`op_b`/`op_ctrl`.
  - Legal non-MUL → EXEC.
  - MUL → MUL, with acc=0, mcand=req_a, mplier=req_b.
  - Illegal → DONE, with rsp_data=0 and rsp_err=1.
- EXEC: drive alu_a=op_a, alu_b=op_b, alu_ctrl=op_ctrl. Register alu_result into rsp_data, set rsp_err=0, → DONE.
- MUL:
  - Each cycle: alu_a=acc, alu_b=mcand, alu_ctrl=ADD.
  - If mplier[0]=1, acc←alu_result.
  - Then mcand←mcand<<1 and mplier←mplier>>1 (logical).
  - When the post-shift mplier is 0, or after 32 iterations: rsp_data←final acc, → DONE.
  - If mplier=0 on entry: zero iterations are spent; the block goes straight to DONE with rsp_data=0.
- Arithmetic wraps mod 2^32. MUL returns the low 32 bits of the product; signedness is irrelevant for the low half.
- DONE:
  - `rsp_valid`=1. rsp_data and rsp_err hold stable until `rsp_ready`=1.
  - When rsp_ready=1 → IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Outside EXEC/MUL: alu_a=0, alu_b=0, alu_ctrl=NOP.

## Timing
- Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, alu_a=0, alu_b=0, alu_ctrl=0000. req_ready=0 while reset is high, 1 from the first cycle after.
- Reset mid-operation aborts the current request. There is no response for it.
- Latency from accept edge to rsp_valid:
  - ADD/SUB/AND/OR: 2 cycles.
  - Illegal: 1 cycle.
  - MUL: 1 + k cycles, where k = index of the highest set bit of req_b, plus 1 (max 33).
- req_ready is a pure function of state, with no combinational path from req_valid. rsp_valid is registered.
- Throughput: one request in flight. Back-to-back ADDs with rsp_ready held high give one result every 3 cycles.
- alu_result is sampled in the same cycle the ALU inputs are driven. This relies on the ALU being purely combinational.

## Structure
- Shared package `alu_pkg` holds:
  - ALU_ADD/SUB/AND/OR/NOP localparams.
  - FUNCT3/FUNCT7 constants.
  - State encoding.
- The ALU itself must include `alu_pkg` for its codes.
- One sub-module: `alu_op_decode`, combinational. It maps (funct7, funct3) → {alu_ctrl, is_mul, illegal}.
- Iteration counter: 6 bits.

## Test plan
- Reset, then ADD 0x0000_0005 + 0x0000_0003 → rsp_valid 2 cycles after accept, rsp_data=0x8, rsp_err=0, alu_ctrl=0001 during EXEC only.
- SUB 0 − 1 → 0xFFFF_FFFF. AND 0xF0F0_F0F0 & 0xFF00_FF00 → 0xF000_F000. OR → 0xFFF0_FFF0.
- MUL cases:
  - 7 × 6 → 0x2A after 4 cycles.
  - 0x1234 × 0 → 0 after 1 cycle.
  - 0xFFFF_FFFF × 0xFFFF_FFFF → 0x0000_0001 after 33 cycles.
- funct7=0000000, funct3=001 → rsp_err=1, rsp_data=0, 1-cycle latency, alu_ctrl stays 0000.
- Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_data stable, req_ready=0. Then release → IDLE next cycle.
- Assert reset during MUL iteration 10 → next cycle all outputs at reset values, no response. A subsequent ADD completes normally.
